// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - state type and sizing helpers for piso_serializer.
// Defining PISO_PARITY_EN adds one even-parity bit to every word.
package piso_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int piso_cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

  function automatic int piso_nbits(input int width);
`ifdef PISO_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// rtl/piso_bit_counter.sv - clearable up-counter flagging the final bit of a word.
module piso_bit_counter #(
  parameter int NBITS = 4,
  parameter int CW    = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam logic [CW-1:0] TC_VAL = CW'(NBITS - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == TC_VAL);

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out stage with gapless back-to-back words.
// PISO_PARITY_EN appends an even-parity bit after the data bits.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] parallel_in,
  output logic             serial_out,
  output logic             frame,
  output logic             last,
  output logic             busy
);

  localparam int NBITS = piso_nbits(WIDTH);
  localparam int CW    = piso_cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [NBITS-1:0] shreg_q, shreg_d, load_word;
  logic             in_shift, accept, tc, head;

  assign in_shift   = (state_q == SHIFT);
  assign load_ready = !in_shift || tc;
  assign accept     = load_valid && load_ready;

  // The head bit always sits at the output end, so shifting only moves toward it.
  always_comb begin
`ifdef PISO_PARITY_EN
    load_word = MSB_FIRST ? {parallel_in, ^parallel_in} : {^parallel_in, parallel_in};
`else
    load_word = parallel_in;
`endif
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    if (accept) begin
      state_d = SHIFT;
      shreg_d = load_word;
    end else if (in_shift) begin
      shreg_d = MSB_FIRST ? {shreg_q[NBITS-2:0], 1'b0} : {1'b0, shreg_q[NBITS-1:1]};
      if (tc) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

  piso_bit_counter #(
    .NBITS (NBITS),
    .CW    (CW)
  ) u_bit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept || (in_shift && tc)),
    .inc   (in_shift),
    .tc    (tc)
  );

  assign head       = MSB_FIRST ? shreg_q[NBITS-1] : shreg_q[0];
  assign serial_out = in_shift && head;
  assign frame      = in_shift;
  assign busy       = in_shift;
  assign last       = in_shift && tc;

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out stage that sits directly upstream of the team's sipo deserializer.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clk on serial_out.
- frame and last strobes let the downstream deserializer or a protocol block track word boundaries.
- Supports gapless back-to-back words.

Parameters:
- WIDTH, 4, word width in bits; must be >= 2.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load_valid  input  1  upstream has a word on parallel_in.
- load_ready  output  1  block can accept a word this cycle.
- parallel_in  input  WIDTH  word to serialize; sampled only on an accepted handshake.
- serial_out  output  1  current serial bit; 0 when frame=0.
- frame  output  1  high on every cycle that serial_out carries a data (or parity) bit.
- last  output  1  high on the final bit of the current word.
- busy  output  1  high while in SHIFT state.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, shift register=0, bit counter=0.
  - Outputs: serial_out=0, frame=0, last=0, busy=0, load_ready=1.
  - Takes effect immediately, mid-word included; the partial word is discarded and never resumed.
- States: IDLE, SHIFT.
- Accept: handshake fires on a rising edge with load_valid=1 and load_ready=1.
- load_ready = (state==IDLE) or (state==SHIFT and last=1). It is combinational from registered state only; it never depends on load_valid.
- IDLE:
  - On accept: capture parallel_in, counter=0, go to SHIFT.
  - Otherwise stay; serial_out=0, frame=0.
- SHIFT:
  - frame=1, busy=1, serial_out = current head bit of the shift register.
  - Each edge: shift one position toward the output end; counter+1.
- Bit count per word: NBITS=WIDTH, or WIDTH+1 with parity enabled.
- last=1 when counter==NBITS-1.
- On the last-bit edge:
  - With accept: load the new word, counter=0, stay in SHIFT. The next cycle carries bit 0 of the new word, so frame stays high with no idle gap.
  - Without accept: go to IDLE; frame drops the following cycle.
- Latency: first bit appears on serial_out the cycle after the accept edge.
- A word of WIDTH bits occupies exactly NBITS consecutive frame cycles.
- load_valid while SHIFT and last=0: not accepted; upstream must hold parallel_in and load_valid until load_ready.
- parallel_in changes outside an accept edge have no effect.
- Counter width is clog2(WIDTH+2); no wrap-around beyond NBITS-1 is ever reachable.
- All outputs are registered or decoded from registered state; no combinational path from inputs to serial_out, frame, last or busy.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined: an even-parity bit (XOR of the captured word) is appended after the data bits. NBITS=WIDTH+1; last asserts on the parity bit; the parity bit is computed at capture time.
- Undefined: no parity logic; NBITS=WIDTH; last on the final data bit.

Decomposition:
- Package piso_pkg holds:
  - state enum {IDLE, SHIFT};
  - localparam function for counter width;
  - NBITS derivation, guarded by PISO_PARITY_EN.
- One natural sub-module: piso_bit_counter. It is a loadable up-counter with a terminal-count flag, parameterized by NBITS, with the same async active-low reset. It drives last.
- Shift/capture datapath and FSM stay in piso_serializer.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> serial_out=0, frame=0, last=0, busy=0, load_ready=1. Assert rst_n=0 mid-word -> all outputs return to those values without waiting for clk.
- Single word, WIDTH=4, MSB_FIRST=1: accept 4'b1011 -> serial_out 1,0,1,1 on the next 4 cycles; frame high for exactly those 4 cycles; last only on the 4th; load_ready=0 on cycles 1-3.
- Back-to-back: 4'b1011 then 4'b0110, with load_valid held high -> 8 contiguous bits 1,0,1,1,0,1,1,0; frame never drops; second word accepted on the first word's last-bit edge.
- Busy rejection: drive load_valid=1 with 4'b1111 during bit 2 of 4'b0000 -> no accept until last; output is 0,0,0,0 then 1,1,1,1.
- MSB_FIRST=0, 4'b1000 -> serial_out 0,0,0,1. With PISO_PARITY_EN: 4'b1011 (MSB_FIRST=1) -> 1,0,1,1,1, last on the 5th bit, frame high for 5 cycles.
- Loopback: connect serial_out into the team's 4-bit sipo serial_in on the same clk, and send random words -> after each word's last bit, sipo parallel_out equals the sent word for the matching bit order (1000 words, zero mismatches).
